// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: datapath width,
// PC increment and the {pc, inst} entry carried between the two stages.
package fetch_queue_pkg;

  localparam int WIDTH  = 32;
  localparam int PC_INC = 4;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the prefetch queue: one synchronous write port and one
// combinational read port; contents are never reset.
module queue_storage #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode. Handshake and occupancy
// depend only on registered state; a branch flush empties the queue.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = fetch_queue_pkg::WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_pc,
  input  logic [WIDTH-1:0]           in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_pc,
  output logic [WIDTH-1:0]           out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [2*WIDTH-1:0] rd_data;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  queue_storage #(
    .DEPTH  (DEPTH),
    .DATA_W (2*WIDTH),
    .ADDR_W (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wp_q),
    .wdata ({in_pc, in_inst}),
    .raddr (rp_q),
    .rdata (rd_data)
  );

  // Stale storage is never exposed: an empty queue presents zeros.
  assign out_pc   = out_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
  assign out_inst = out_valid ? rd_data[WIDTH-1:0]       : '0;
  assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the prefetch buffer.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_pc = '0;
  logic [WIDTH-1:0] in_inst = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_inst;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;

  fetch_entry_t model_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    fetch_entry_t head;
    head = '0;
    if (model_q.size() != 0) head = model_q[0];
    check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    check("in_ready",  64'(in_ready),  64'(model_q.size() != DEPTH));
    check("count",     64'(count),     64'(model_q.size()));
    check("out_pc",    64'(out_pc),    64'(head.pc));
    check("out_inst",  64'(out_inst),  64'(head.inst));
  endtask

  // Drive one cycle's inputs, check the registered-state outputs, advance the model.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] i,
                       input logic r, input logic f);
    bit acc, pp;
    in_valid  = v;
    in_pc     = p;
    in_inst   = i;
    out_ready = r;
    flush     = f;
    check_outputs();
    acc = v && (model_q.size() < DEPTH);
    pp  = r && (model_q.size() > 0);
    if (f) begin
      model_q.delete();
    end else begin
      if (pp)  void'(model_q.pop_front());
      if (acc) model_q.push_back('{pc: p, inst: i});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] pc;

    // Reset then idle
    #3;
    check_outputs();
    #9 rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, '0, 1'b0, 1'b0);

    // Fill to full, refused fifth push, drain in order
    for (int k = 1; k <= 4; k++)
      cycle(1'b1, WIDTH'(k * PC_INC), 32'hE3A00000 + 32'(k), 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 32'd20, 32'hE3A00005, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Streaming with pointer wrap
    pc = 32'd200;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, pc, 32'hE2800000 + 32'(k), 1'b1, 1'b0);
      pc += PC_INC;
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with a concurrent push, then a fresh push
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'(300 + 4 * k), 32'hE0800000 + 32'(k), 1'b0, 1'b0);
    cycle(1'b1, 32'd40, 32'hEA000010, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    cycle(1'b1, 32'd100, 32'hE1A00000, 1'b0, 1'b0);
    check("flush_head", 64'(out_inst), 64'hE1A00000);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Pop while full refuses the simultaneous push
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'(500 + 4 * k), 32'hE5900000 + 32'(k), 1'b0, 1'b0);
    cycle(1'b1, 32'd600, 32'hDEADBEEF, 1'b1, 1'b0);
    check("stall_count", 64'(count), 64'd3);
    check("stall_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges
    cycle(1'b1, 32'd700, 32'hE3A0000A, 1'b0, 1'b0);
    cycle(1'b1, 32'd704, 32'hE3A0000B, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    model_q.delete();
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check_outputs();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 9) < 7), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    for (int k = 0; k < DEPTH + 1; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
